// File: rtl/scn_rom_responder.sv
// ---------------------------------------------------------------------------
// scn_rom_responder: toggle-handshake graphics ROM responder backed by a
// one-line (64-bit) cache that refills over an SDRAM req/ack read channel.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scn_rom_responder #(
  parameter int                SDR_AW    = 27,
  parameter logic [SDR_AW-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [20:0]       rom_address,
  input  logic              rom_req,
  output logic              rom_ack,
  output logic [31:0]       rom_data,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [63:0]       sdr_data,
  input  logic              invalidate
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    FETCH   = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [18:0]         req_addr_q, req_addr_d;   // rom_address[20:2]
  logic [17:0]         tag_q, tag_d;             // rom_address[20:3]
  logic                valid_q, valid_d;
  logic [63:0]         line_q, line_d;
  logic                rom_ack_q, rom_ack_d;
  logic [31:0]         rom_data_q, rom_data_d;
  logic                sdr_req_q, sdr_req_d;
  logic [SDR_AW-1:0]   sdr_addr_q, sdr_addr_d;
  logic                inval_seen_q, inval_seen_d;

  logic                pending;
  logic                hit;
  logic [31:0]         line_word;
  logic [SDR_AW-1:0]   line_byte_addr;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^rom_address[1:0];

  assign pending        = (rom_req != rom_ack_q);
  assign hit            = valid_q && (tag_q == req_addr_q[18:1]) && !invalidate;
  assign line_word      = req_addr_q[0] ? line_q[63:32] : line_q[31:0];
  assign line_byte_addr = SDR_AW'({req_addr_q[18:1], 3'b000});

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    tag_d        = tag_q;
    valid_d      = valid_q & ~invalidate;
    line_d       = line_q;
    rom_ack_d    = rom_ack_q;
    rom_data_d   = rom_data_q;
    sdr_req_d    = sdr_req_q;
    sdr_addr_d   = sdr_addr_q;
    inval_seen_d = inval_seen_q;

    case (state_q)
      IDLE: begin
        if (pending) begin
          req_addr_d = rom_address[20:2];
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        // A second toggle that re-matched the levels cancels the request.
        if (!pending) begin
          state_d = IDLE;
        end else if (hit) begin
          rom_data_d = line_word;
          rom_ack_d  = rom_req;
          state_d    = IDLE;
        end else begin
          sdr_addr_d   = BASE_ADDR + line_byte_addr;
          sdr_req_d    = 1'b1;
          inval_seen_d = 1'b0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (invalidate) begin
          inval_seen_d = 1'b1;
        end
        if (sdr_ack) begin
          line_d    = sdr_data;
          tag_d     = req_addr_q[18:1];
          sdr_req_d = 1'b0;
          valid_d   = !invalidate && !inval_seen_q;
          state_d   = RESPOND;
        end
      end
      RESPOND: begin
        rom_data_d = line_word;
        rom_ack_d  = rom_req;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      line_q       <= '0;
      rom_ack_q    <= 1'b0;
      rom_data_q   <= '0;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      inval_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      line_q       <= line_d;
      rom_ack_q    <= rom_ack_d;
      rom_data_q   <= rom_data_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      inval_seen_q <= inval_seen_d;
    end
  end

  assign rom_ack  = rom_ack_q;
  assign rom_data = rom_data_q;
  assign sdr_req  = sdr_req_q;
  assign sdr_addr = sdr_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_scn_rom_responder.sv
// ---------------------------------------------------------------------------
// tb_scn_rom_responder: directed bench for scn_rom_responder (two instances,
// default and offset BASE_ADDR).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_scn_rom_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [20:0] rom_address;
  logic        rom_req;
  logic        sdr_ack;
  logic [63:0] sdr_data;
  logic        invalidate;

  logic        rom_ack_a, rom_ack_b;
  logic [31:0] rom_data_a, rom_data_b;
  logic [26:0] sdr_addr_a, sdr_addr_b;
  logic        sdr_req_a, sdr_req_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  scn_rom_responder #(.SDR_AW(27), .BASE_ADDR(27'h0)) u_dut (
    .clk(clk), .reset_n(reset_n), .rom_address(rom_address), .rom_req(rom_req),
    .rom_ack(rom_ack_a), .rom_data(rom_data_a), .sdr_addr(sdr_addr_a),
    .sdr_req(sdr_req_a), .sdr_ack(sdr_ack), .sdr_data(sdr_data),
    .invalidate(invalidate)
  );

  scn_rom_responder #(.SDR_AW(27), .BASE_ADDR(27'h400000)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .rom_address(rom_address), .rom_req(rom_req),
    .rom_ack(rom_ack_b), .rom_data(rom_data_b), .sdr_addr(sdr_addr_b),
    .sdr_req(sdr_req_b), .sdr_ack(sdr_ack), .sdr_data(sdr_data),
    .invalidate(invalidate)
  );

  // Advance n rising edges; inputs change and outputs are sampled 1ns after.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle sdr_ack pulse carrying the given line.
  task automatic sdr_pulse(input logic [63:0] data);
    sdr_ack  = 1'b1;
    sdr_data = data;
    tick(1);
    sdr_ack  = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    rom_address = '0;
    rom_req     = 1'b0;
    sdr_ack     = 1'b0;
    sdr_data    = '0;
    invalidate  = 1'b0;
    tick(3);
    chk("reset_rom_ack",  rom_ack_a,  0);
    chk("reset_rom_data", rom_data_a, 0);
    chk("reset_sdr_req",  sdr_req_a,  0);
    chk("reset_sdr_addr", sdr_addr_a, 0);
    reset_n = 1'b1;
    tick(2);

    // Cold miss on 0x104 (upper word of line 0x100).
    rom_address = 21'h000104;
    rom_req     = 1'b1;
    tick(1);
    chk("miss1_sdr_req_early", sdr_req_a, 0);
    tick(1);
    chk("miss1_sdr_req",    sdr_req_a,  1);
    chk("miss1_sdr_addr",   sdr_addr_a, 27'h100);
    chk("miss1_sdr_addr_b", sdr_addr_b, 27'h400100);
    tick(2);
    chk("miss1_sdr_req_hold", sdr_req_a, 1);
    chk("miss1_ack_wait",     rom_ack_a, 0);
    sdr_pulse(64'hDDDDCCCC_BBBBAAAA);
    chk("miss1_sdr_req_drop", sdr_req_a, 0);
    chk("miss1_ack_not_yet",  rom_ack_a, 0);
    tick(1);
    chk("miss1_rom_data", rom_data_a, 32'hDDDDCCCC);
    chk("miss1_rom_ack",  rom_ack_a,  1);

    // Hit on the lower word of the cached line.
    rom_address = 21'h000100;
    rom_req     = 1'b0;
    tick(1);
    chk("hit_ack_not_yet", rom_ack_a,  1);
    chk("hit_data_stable", rom_data_a, 32'hDDDDCCCC);
    tick(1);
    chk("hit_rom_data", rom_data_a, 32'hBBBBAAAA);
    chk("hit_rom_ack",  rom_ack_a,  0);
    chk("hit_sdr_req",  sdr_req_a,  0);

    // Tag change forces a refill of line 0x108.
    rom_address = 21'h000108;
    rom_req     = 1'b1;
    tick(2);
    chk("tag_sdr_req",    sdr_req_a,  1);
    chk("tag_sdr_addr",   sdr_addr_a, 27'h108);
    chk("tag_sdr_addr_b", sdr_addr_b, 27'h400108);
    tick(1);
    sdr_pulse(64'h22222222_11111111);
    tick(1);
    chk("tag_rom_data", rom_data_a, 32'h11111111);
    chk("tag_rom_ack",  rom_ack_a,  1);

    // Invalidate during fetch: data returned but not cached.
    rom_address = 21'h00020C;
    rom_req     = 1'b0;
    tick(2);
    chk("inv_sdr_req",  sdr_req_a,  1);
    chk("inv_sdr_addr", sdr_addr_a, 27'h208);
    invalidate = 1'b1;
    tick(1);
    invalidate = 1'b0;
    tick(1);
    sdr_pulse(64'h44444444_33333333);
    tick(1);
    chk("inv_rom_data", rom_data_a, 32'h44444444);
    chk("inv_rom_ack",  rom_ack_a,  0);
    rom_req = 1'b1;
    tick(2);
    chk("inv_rerequest_miss", sdr_req_a, 1);
    sdr_pulse(64'h44444444_33333333);
    tick(1);
    chk("inv_re_rom_data", rom_data_a, 32'h44444444);
    chk("inv_re_rom_ack",  rom_ack_a,  1);

    // Line 0x208 is now cached: same address hits.
    rom_address = 21'h000208;
    rom_req     = 1'b0;
    tick(2);
    chk("cached_hit_data", rom_data_a, 32'h33333333);
    chk("cached_hit_ack",  rom_ack_a,  0);
    chk("cached_hit_nofetch", sdr_req_a, 0);

    // Reset asserted mid-fetch.
    rom_address = 21'h000300;
    rom_req     = 1'b1;
    tick(2);
    chk("rst_fetch_sdr_req", sdr_req_a, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_sdr_req",  sdr_req_a,  0);
    chk("rst_async_sdr_addr", sdr_addr_a, 0);
    chk("rst_async_rom_data", rom_data_a, 0);
    chk("rst_async_rom_ack",  rom_ack_a,  0);
    tick(2);
    rom_req = 1'b0;
    reset_n = 1'b1;
    tick(1);
    sdr_pulse(64'hFFFFFFFF_EEEEEEEE);
    tick(2);
    chk("rst_late_ack_rom_ack",  rom_ack_a,  0);
    chk("rst_late_ack_rom_data", rom_data_a, 0);
    chk("rst_late_ack_sdr_req",  sdr_req_a,  0);
    rom_address = 21'h00020C;
    rom_req     = 1'b1;
    tick(2);
    chk("rst_next_miss", sdr_req_a, 1);
    sdr_pulse(64'h66666666_55555555);
    tick(1);
    chk("rst_next_rom_data", rom_data_a, 32'h66666666);
    chk("rst_next_rom_ack",  rom_ack_a,  1);

    // Double toggle on a missing address collapses the request.
    rom_address = 21'h000500;
    rom_req     = 1'b0;
    tick(1);
    rom_req     = 1'b1;
    tick(1);
    chk("dbl_sdr_req_0", sdr_req_a, 0);
    tick(3);
    chk("dbl_sdr_req",   sdr_req_a,  0);
    chk("dbl_rom_ack",   rom_ack_a,  1);
    chk("dbl_rom_data",  rom_data_a, 32'h66666666);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
